dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum consecutive contested cycles the core wins before the DMA port is granted.
REQ-002 SHALL have parameter ADDR_BITS, default 7, meaning the number of word-address bits decoded by the data memory (128 words).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports core_req, core_we  input  1 each  core access request and write enable.
REQ-006 SHALL have ports core_addr, core_wdata  input  32 each  core address and write data.
REQ-007 SHALL have ports core_gnt, core_rvalid  output  1 each  core grant (same cycle) and read-data valid.
REQ-008 SHALL have port core_rdata  output  32  core read data.
REQ-009 SHALL have ports dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata with the same directions, widths and meanings as the core_* ports.
REQ-010 SHALL have ports mem_addr  output  32, mem_we  output  1, mem_wd  output  32, all driven to the data memory.
REQ-011 SHALL have port mem_rd  input  32  combinational read data from the data memory (the memory returns 0 while mem_we=1).
REQ-012 SHALL have port addr_err  output  1  one-cycle pulse for a granted out-of-range access.

Function
REQ-013 SHALL grant at most one port per cycle; core_gnt and dma_gnt are combinational from the *_req inputs and starve_cnt.
REQ-014 SHALL grant the core when only core_req=1, and the DMA port when only dma_req=1.
REQ-015 SHALL, when both request, grant the core if starve_cnt<STARVE_LIMIT, else grant the DMA port.
REQ-016 SHALL increment starve_cnt (saturating at STARVE_LIMIT) on each cycle where both request and the core is granted.
REQ-017 SHALL clear starve_cnt to 0 on any cycle where dma_gnt=1 or dma_req=0.
REQ-018 SHALL drive mem_addr and mem_wd from the granted port in the grant cycle, and 0 when there is no grant.
REQ-019 SHALL drive mem_we = granted port's *_we AND in-range, and 0 when there is no grant.
REQ-020 SHALL treat an address as in range when addr[31:ADDR_BITS]==0.
REQ-021 SHALL, for a granted out-of-range access, suppress the write, pulse addr_err in the following cycle, and return rdata=0 for reads.
REQ-022 SHALL register mem_rd at the rising edge ending the grant cycle of a granted read, into the granted port's *_rdata, with *_rvalid=1 for exactly the next cycle (read latency 1).
REQ-023 SHALL hold *_rdata between reads; *_rvalid SHALL stay 0 after writes and after ungranted cycles.
REQ-024 SHALL leave ungranted requesters to hold req, we, addr and wdata stable until granted; there is no queueing inside the block.
REQ-025 SHALL support back-to-back grants every cycle, including alternating ports, with no bubble.

Reset
REQ-026 SHALL, on a rising edge with rst_n=0, set starve_cnt=0, core_rvalid=0, dma_rvalid=0, addr_err=0, core_rdata=0 and dma_rdata=0.
REQ-027 SHALL force core_gnt=0, dma_gnt=0 and mem_we=0 combinationally while rst_n=0, so no write occurs during reset.
REQ-028 SHALL discard an access whose grant cycle coincides with reset: no rvalid and no addr_err afterwards.

Verification
REQ-029 Core write addr=0x10, wdata=0xDEADBEEF, then core read 0x10 -> mem_we=1 in the write cycle; core_rvalid=1 one cycle after the read grant with core_rdata=0xDEADBEEF.
REQ-030 Both ports continuously request reads, STARVE_LIMIT=4 -> grant pattern core,core,core,core,dma repeating; dma_rvalid appears one cycle after each DMA grant.
REQ-031 DMA-only write addr=0x7F, then core read 0x7F -> dma_gnt=1 immediately; core_rdata equals the DMA write data.
REQ-032 Core write to addr=0x80 -> mem_we=0, addr_err=1 for one cycle; a subsequent read of 0x00 is unchanged.
REQ-033 rst_n=0 during a core read grant cycle -> core_rvalid stays 0 and starve_cnt=0 afterwards; first grant after reset goes to the core under contention.
REQ-034 Alternating single-port reads core/dma/core on consecutive cycles -> each *_rvalid pulses exactly once, one cycle after its own grant, with correct data.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port (core, DMA) arbiter in front of a single-ported data memory.
// Core has priority under contention, but the DMA port is forced through after STARVE_LIMIT core wins.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_BITS    = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        addr_err
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    // Index 0 is the core port, index 1 the DMA port.
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0]       gnt;
    logic [1:0]       in_range;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;

    logic [CW-1:0] starve_cnt_reg;
    logic [CW-1:0] starve_cnt_next;
    logic          addr_err_reg;
    logic          dma_turn;

    assign req   = {dma_req, core_req};
    assign we    = {dma_we, core_we};
    assign addr  = {dma_addr, core_addr};
    assign wdata = {dma_wdata, core_wdata};

    assign dma_turn = (starve_cnt_reg >= LIMIT);

    // Grants are masked by reset so nothing reaches the memory while rst_n is low.
    assign gnt[0] = rst_n & req[0] & ~(req[1] & dma_turn);
    assign gnt[1] = rst_n & req[1] & (~req[0] | dma_turn);

    assign core_gnt = gnt[0];
    assign dma_gnt  = gnt[1];

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (gnt[1] || !req[1]) begin
            starve_cnt_next = '0;
        end else if (req[0] && gnt[0] && (starve_cnt_reg < LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_wd   = '0;
        mem_we   = 1'b0;
        if (gnt[0]) begin
            mem_addr = addr[0];
            mem_wd   = wdata[0];
            mem_we   = we[0] & in_range[0];
        end else if (gnt[1]) begin
            mem_addr = addr[1];
            mem_wd   = wdata[1];
            mem_we   = we[1] & in_range[1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic        rvalid_reg;
            logic [31:0] rdata_reg;

            assign in_range[gi] = ~|addr[gi][31:ADDR_BITS];

            // Out-of-range reads still complete, returning zero instead of memory data.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= gnt[gi] & ~we[gi];
                    if (gnt[gi] && !we[gi]) begin
                        rdata_reg <= in_range[gi] ? mem_rd : 32'h0;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
            addr_err_reg   <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            addr_err_reg   <= |(gnt & ~in_range);
        end
    end

    assign core_rvalid = g_port[0].rvalid_reg;
    assign core_rdata  = g_port[0].rdata_reg;
    assign dma_rvalid  = g_port[1].rvalid_reg;
    assign dma_rdata   = g_port[1].rdata_reg;
    assign addr_err    = addr_err_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a 128-word memory model, a cycle-level reference model
// compared at every falling edge, and directed scenarios with literal expectations.
module tb_dmem_arbiter;
    localparam int LIMIT = 4;
    localparam int AB    = 7;

    logic        clk;
    logic        rst_n;
    logic        core_req, core_we, dma_req, dma_we;
    logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata;
    logic        core_gnt, core_rvalid, dma_gnt, dma_rvalid;
    logic [31:0] core_rdata, dma_rdata;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_we, addr_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] dmem [128];
    logic [31:0] model_mem [128];

    dmem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .addr_err(addr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory: combinational read, returns 0 while writing.
    assign mem_rd = mem_we ? 32'h0 : dmem[mem_addr[6:0]];

    initial begin
        for (int i = 0; i < 128; i++) dmem[i] = 32'hA500_0000 | i;
        forever begin
            @(posedge clk);
            if (mem_we) dmem[mem_addr[6:0]] = mem_wd;
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: streak counts consecutive contested cycles the core has won.
    int          streak;
    logic        m_valid, m_crv, m_drv, m_err;
    logic [31:0] m_crd, m_drd;

    initial begin
        logic        eg_c, eg_d, g_we, g_in;
        logic [31:0] g_addr, g_wd, e_addr, e_wd;
        logic        e_we;
        m_valid = 1'b0;
        streak  = 0;
        m_crv = 1'b0; m_drv = 1'b0; m_err = 1'b0; m_crd = '0; m_drd = '0;
        for (int i = 0; i < 128; i++) model_mem[i] = 32'hA500_0000 | i;
        forever begin
            @(negedge clk);
            eg_c = rst_n && core_req && !(dma_req && streak >= LIMIT);
            eg_d = rst_n && dma_req && !eg_c;
            g_addr = eg_c ? core_addr : dma_addr;
            g_wd   = eg_c ? core_wdata : dma_wdata;
            g_we   = eg_c ? core_we : dma_we;
            g_in   = g_addr < (32'd1 << AB);
            e_addr = (eg_c || eg_d) ? g_addr : 32'h0;
            e_wd   = (eg_c || eg_d) ? g_wd : 32'h0;
            e_we   = (eg_c || eg_d) && g_we && g_in;
            if (m_valid) begin
                chk1("m_core_gnt", core_gnt, eg_c);
                chk1("m_dma_gnt", dma_gnt, eg_d);
                chk32("m_mem_addr", mem_addr, e_addr);
                chk32("m_mem_wd", mem_wd, e_wd);
                chk1("m_mem_we", mem_we, e_we);
                chk1("m_core_rvalid", core_rvalid, m_crv);
                chk1("m_dma_rvalid", dma_rvalid, m_drv);
                chk32("m_core_rdata", core_rdata, m_crd);
                chk32("m_dma_rdata", dma_rdata, m_drd);
                chk1("m_addr_err", addr_err, m_err);
            end
            if (!rst_n) begin
                streak = 0;
                m_crv = 1'b0; m_drv = 1'b0; m_err = 1'b0; m_crd = '0; m_drd = '0;
                m_valid = 1'b1;
            end else begin
                m_crv = eg_c && !g_we;
                m_drv = eg_d && !g_we;
                m_err = (eg_c || eg_d) && !g_in;
                if (m_crv) m_crd = g_in ? model_mem[g_addr[6:0]] : 32'h0;
                if (m_drv) m_drd = g_in ? model_mem[g_addr[6:0]] : 32'h0;
                if (e_we) model_mem[g_addr[6:0]] = g_wd;
                if (eg_d || !dma_req) streak = 0;
                else if (core_req && eg_c && streak < LIMIT) streak = streak + 1;
            end
        end
    end

    task automatic drive(input logic rn, input logic cr, input logic cw,
                         input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        rst_n = rn;
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;

        // Reset with a write pending: nothing may be granted or written.
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h1111_1111, 1'b1, 1'b1, 32'h11, 32'h2222_2222);
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h1111_1111, 1'b1, 1'b1, 32'h11, 32'h2222_2222);
        chk1("rst_core_gnt", core_gnt, 1'b0);
        chk1("rst_dma_gnt", dma_gnt, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_core_rvalid", core_rvalid, 1'b0);
        chk32("rst_core_rdata", core_rdata, 32'h0);
        chk1("rst_addr_err", addr_err, 1'b0);

        // Core write then read back.
        drive(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        chk1("wr_core_gnt", core_gnt, 1'b1);
        chk1("wr_mem_we", mem_we, 1'b1);
        chk32("wr_mem_addr", mem_addr, 32'h10);
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk1("wr_core_rvalid_after_write", core_rvalid, 1'b0);
        idle();
        chk1("rd_core_rvalid", core_rvalid, 1'b1);
        chk32("rd_core_rdata", core_rdata, 32'hDEAD_BEEF);
        idle();
        chk1("rd_core_rvalid_once", core_rvalid, 1'b0);
        chk32("rd_core_rdata_hold", core_rdata, 32'hDEAD_BEEF);

        // DMA-only write at the top word, core reads it.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h7F, 32'h1234_5678);
        chk1("dw_dma_gnt", dma_gnt, 1'b1);
        chk1("dw_core_gnt", core_gnt, 1'b0);
        chk1("dw_mem_we", mem_we, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 32'h7F, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        chk1("dw_core_rvalid", core_rvalid, 1'b1);
        chk32("dw_core_rdata", core_rdata, 32'h1234_5678);

        // Out-of-range write is suppressed and flagged; word 0 unchanged.
        drive(1'b1, 1'b1, 1'b1, 32'h80, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk1("oor_core_gnt", core_gnt, 1'b1);
        chk1("oor_mem_we", mem_we, 1'b0);
        idle();
        chk1("oor_addr_err", addr_err, 1'b1);
        idle();
        chk1("oor_addr_err_pulse", addr_err, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        chk32("oor_word0", core_rdata, 32'hA500_0000);
        // Out-of-range read returns zero and flags.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        idle();
        chk1("oor_rd_rvalid", dma_rvalid, 1'b1);
        chk32("oor_rd_rdata", dma_rdata, 32'h0);
        chk1("oor_rd_err", addr_err, 1'b1);

        // Continuous contention: core x4, dma, repeating.
        idle();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h01, 32'h0, 1'b1, 1'b0, 32'h02, 32'h0);
            chk1("starve_dma_gnt", dma_gnt, (i % 5) == 4);
            chk1("starve_core_gnt", core_gnt, (i % 5) != 4);
            chk1("starve_dma_rvalid", dma_rvalid, i == 5);
            if (i == 5) chk32("starve_dma_rdata", dma_rdata, 32'hA500_0002);
            if (i == 1) chk32("starve_core_rdata", core_rdata, 32'hA500_0001);
        end

        // Reset in the middle of contention clears the starvation count.
        idle();
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, 1'b0, 32'h05, 32'h0, 1'b1, 1'b0, 32'h06, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h05, 32'h0, 1'b1, 1'b0, 32'h06, 32'h0);
        chk1("rstc_core_gnt", core_gnt, 1'b0);
        chk1("rstc_dma_gnt", dma_gnt, 1'b0);
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h05, 32'h0, 1'b1, 1'b0, 32'h06, 32'h0);
            chk1("rstc_core_gnt_seq", core_gnt, j != 4);
            if (j == 0) begin
                chk1("rstc_core_rvalid", core_rvalid, 1'b0);
                chk32("rstc_core_rdata", core_rdata, 32'h0);
            end
        end

        // Out-of-range access during reset leaves no trace.
        drive(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        chk1("rsto_addr_err", addr_err, 1'b0);
        chk1("rsto_core_rvalid", core_rvalid, 1'b0);

        // Alternating single-port reads, back to back.
        drive(1'b1, 1'b1, 1'b0, 32'h03, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h04, 32'h0);
        chk1("alt_core_rvalid0", core_rvalid, 1'b1);
        chk32("alt_core_rdata0", core_rdata, 32'hA500_0003);
        chk1("alt_dma_rvalid0", dma_rvalid, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 32'h05, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk1("alt_dma_rvalid1", dma_rvalid, 1'b1);
        chk32("alt_dma_rdata1", dma_rdata, 32'hA500_0004);
        chk1("alt_core_rvalid1", core_rvalid, 1'b0);
        idle();
        chk1("alt_core_rvalid2", core_rvalid, 1'b1);
        chk32("alt_core_rdata2", core_rdata, 32'hA500_0005);
        chk1("alt_dma_rvalid2", dma_rvalid, 1'b0);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
